data_mem_responder: RTL and testbench

- Memory-side responder for the multicycle control unit's data and instruction accesses.
- Accepts one request at a time over a req/ack handshake and applies a configurable number of wait states.
- Performs little-endian byte, halfword or word reads and writes on an internal word-organised RAM.
- Returns the read data, sign- or zero-extended, together with a one-cycle ack. Misaligned accesses are flagged with err.

---
 rtl/mem_pkg.sv | 24 ++
 rtl/mem_lane_align.sv | 56 +++++
 rtl/data_mem_responder.sv | 130 +++++++++++++
 tb/tb_data_mem_responder.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the data memory responder: access sizes, FSM states
// and the alignment rule.
package mem_pkg;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_t;

  // Size code 3 behaves as a word access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addrLo);
    case (size)
      SIZE_B:  return 1'b0;
      SIZE_H:  return addrLo[0];
      default: return (addrLo != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane logic: merges a sub-word store into an old word and
// extracts/extends a sub-word load.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [1:0]  addrLo,
  output logic [31:0] newWord,
  output logic [31:0] loadData
);

  logic [3:0]  laneEn;
  logic [31:0] storeRep;
  logic [7:0]  loByte;
  logic [15:0] loHalf;

  always_comb begin
    laneEn   = 4'b1111;
    storeRep = wdata;
    case (size)
      SIZE_B: begin
        laneEn   = 4'b0001 << addrLo;
        storeRep = {4{wdata[7:0]}};
      end
      SIZE_H: begin
        laneEn   = addrLo[1] ? 4'b1100 : 4'b0011;
        storeRep = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Store data is replicated so each enabled lane simply takes its own byte.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : gLane
      assign newWord[gi*8 +: 8] = laneEn[gi] ? storeRep[gi*8 +: 8] : word[gi*8 +: 8];
    end
  endgenerate

  assign loByte = word[{addrLo, 3'b000} +: 8];
  assign loHalf = addrLo[1] ? word[31:16] : word[15:0];

  always_comb begin
    loadData = word;
    case (size)
      SIZE_B:  loadData = {{24{~uns & loByte[7]}}, loByte};
      SIZE_H:  loadData = {{16{~uns & loHalf[15]}}, loHalf};
      default: ;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder: one request at a time, configurable wait states,
// byte/halfword/word access to a word-organised RAM with misalignment flag.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        ack,
  output logic        err,
  output logic [31:0] rdata
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  mem_state_t state;
  logic [3:0]       counter;
  logic             weReg;
  logic             unsReg;
  logic [1:0]       sizeReg;
  logic [IDX_W+1:0] addrReg;
  logic [31:0]      wdataReg;

  logic [31:0] ram [DEPTH_WORDS];

  logic             accIdle;
  logic             accWe;
  logic             accUns;
  logic [1:0]       accSize;
  logic [IDX_W+1:0] accAddr;
  logic [31:0]      accWdata;
  logic             enterResp;
  logic             misaligned;
  logic [IDX_W-1:0] wordIdx;
  logic [31:0]      newWord;
  logic [31:0]      loadData;
  logic             unusedAddrHi;

  // With zero wait states the access happens on the accept edge itself,
  // before the latched copy exists, so the live inputs are used there.
  assign accIdle  = (state == IDLE);
  assign accWe    = accIdle ? we    : weReg;
  assign accUns   = accIdle ? uns   : unsReg;
  assign accSize  = accIdle ? size  : sizeReg;
  assign accAddr  = accIdle ? addr[IDX_W+1:0] : addrReg;
  assign accWdata = accIdle ? wdata : wdataReg;

  assign enterResp  = (accIdle && req && (WAIT_CYCLES == 0)) ||
                      ((state == WAIT) && (counter == 4'd1));
  assign misaligned = is_misaligned(accSize, accAddr[1:0]);
  assign wordIdx    = accAddr[IDX_W+1:2];

  assign unusedAddrHi = ^addr[31:IDX_W+2];

  mem_lane_align uAlign (
    .word     (ram[wordIdx]),
    .wdata    (accWdata),
    .size     (accSize),
    .uns      (accUns),
    .addrLo   (accAddr[1:0]),
    .newWord  (newWord),
    .loadData (loadData)
  );

  // RAM has no reset; the write only ever happens on the RESP-entry edge.
  always_ff @(posedge clk) begin
    if (enterResp && accWe && !misaligned) begin
      ram[wordIdx] <= newWord;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      counter  <= 4'd0;
      busy     <= 1'b0;
      ack      <= 1'b0;
      err      <= 1'b0;
      rdata    <= 32'd0;
      weReg    <= 1'b0;
      unsReg   <= 1'b0;
      sizeReg  <= SIZE_B;
      addrReg  <= '0;
      wdataReg <= 32'd0;
    end else begin
      if (enterResp) begin
        ack   <= 1'b1;
        err   <= misaligned;
        rdata <= (accWe || misaligned) ? 32'd0 : loadData;
      end
      case (state)
        IDLE: begin
          if (req) begin
            weReg    <= we;
            unsReg   <= uns;
            sizeReg  <= size;
            addrReg  <= addr[IDX_W+1:0];
            wdataReg <= wdata;
            counter  <= WAIT_INIT;
            busy     <= 1'b1;
            state    <= (WAIT_CYCLES == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          counter <= counter - 4'd1;
          if (counter == 4'd1) begin
            state <= RESP;
          end
        end
        RESP: begin
          ack   <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench: three responders (3, 1 and 0 wait states), a vector
// table, hand-written corner sequences and a randomised byte-level model.
module tb_data_mem_responder;
  localparam int NDUT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req   [NDUT];
  logic        we    [NDUT];
  logic [1:0]  size  [NDUT];
  logic        uns   [NDUT];
  logic [31:0] addr  [NDUT];
  logic [31:0] wdata [NDUT];
  logic        busy  [NDUT];
  logic        ack   [NDUT];
  logic        err   [NDUT];
  logic [31:0] rdata [NDUT];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < NDUT; gi++) begin : gDut
      data_mem_responder #(
        .DEPTH_WORDS (256),
        .WAIT_CYCLES ((gi == 0) ? 3 : (gi == 1) ? 1 : 0)
      ) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req[gi]),
        .we    (we[gi]),
        .size  (size[gi]),
        .uns   (uns[gi]),
        .addr  (addr[gi]),
        .wdata (wdata[gi]),
        .busy  (busy[gi]),
        .ack   (ack[gi]),
        .err   (err[gi]),
        .rdata (rdata[gi])
      );
    end
  endgenerate

  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic        u;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] expR;
    logic        expE;
    string       nm;
  } vec_t;

  // byte-addressed model of the 1 KiB RAM of instance 1
  logic [7:0] mb [1024];

  function automatic int waitOf(input int d);
    return (d == 0) ? 3 : (d == 1) ? 1 : 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // One complete transaction; inputs are scrambled while waiting to show they are ignored.
  task automatic access(input int d, input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic e);
    int cyc;
    @(negedge clk);
    req[d] = 1'b1; we[d] = w; size[d] = sz; uns[d] = u; addr[d] = a; wdata[d] = wd;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (!ack[d]) begin
        we[d] = ~w; addr[d] = $urandom; wdata[d] = $urandom; size[d] = 2'($urandom_range(0, 3));
      end
    end while (!ack[d] && cyc < 40);
    req[d] = 1'b0;
    chk("ack_latency", 32'(cyc), 32'(waitOf(d) + 1));
    chk("busy_at_ack", 32'(busy[d]), 32'd1);
    rd = rdata[d];
    e  = err[d];
    $display("txn dut=%0d we=%0d size=%0d uns=%0d addr=%h wdata=%h -> rdata=%h err=%0d lat=%0d",
             d, w, sz, u, a, wd, rd, e, cyc);
  endtask

  function automatic void model(input logic w, input logic [1:0] sz, input logic u,
                                input logic [31:0] a, input logic [31:0] wd,
                                output logic [31:0] r, output logic e);
    int n;
    int base;
    longint v;
    n    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    base = int'(a % 1024);
    e    = (base % n) != 0;
    r    = 32'd0;
    if (e) return;
    if (w) begin
      for (int i = 0; i < n; i++) mb[base + i] = wd[8*i +: 8];
    end else begin
      v = 0;
      for (int i = 0; i < n; i++) v = v + (longint'(mb[base + i]) << (8 * i));
      if (!u && n < 4 && mb[base + n - 1][7]) v = v - (longint'(1) << (8 * n));
      r = v[31:0];
    end
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[$];
    logic [31:0] rd;
    logic e;
    logic [31:0] mr;
    logic me;

    for (int d = 0; d < NDUT; d++) begin
      req[d] = 0; we[d] = 0; size[d] = 0; uns[d] = 0; addr[d] = 0; wdata[d] = 0;
    end

    // reset state
    repeat (3) @(negedge clk);
    for (int d = 0; d < NDUT; d++) chk("busy_in_reset", 32'(busy[d]), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      chk("reset_busy", 32'(busy[d]), 32'd0);
      chk("reset_ack", 32'(ack[d]), 32'd0);
      chk("reset_err", 32'(err[d]), 32'd0);
      chk("reset_rdata", rdata[d], 32'd0);
    end

    // reset in the middle of a 3-wait-state write abandons it
    access(0, 1'b1, 2'd2, 1'b0, 32'h10, 32'h0, rd, e);
    @(negedge clk);
    req[0] = 1; we[0] = 1; size[0] = 2'd2; uns[0] = 0; addr[0] = 32'h10; wdata[0] = 32'hDEADBEEF;
    @(negedge clk);
    chk("busy_in_wait", 32'(busy[0]), 32'd1);
    req[0] = 0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("busy_async_reset", 32'(busy[0]), 32'd0);
    chk("ack_async_reset", 32'(ack[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    access(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, e);
    chk("abandoned_write_rdata", rd, 32'h0);
    chk("abandoned_write_err", 32'(e), 32'd0);

    // vector table on the 1-wait-state instance
    vecs.push_back('{1'b1, 2'd2, 1'b0, 32'h020, 32'h12345678, 32'h00000000, 1'b0, "sw20"});
    vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h020, 32'h0,        32'h12345678, 1'b0, "lw20"});
    vecs.push_back('{1'b1, 2'd0, 1'b0, 32'h021, 32'hFFFFFFAB, 32'h00000000, 1'b0, "sb21"});
    vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h020, 32'h0,        32'h1234AB78, 1'b0, "lw20_after_sb"});
    vecs.push_back('{1'b0, 2'd0, 1'b0, 32'h021, 32'h0,        32'hFFFFFFAB, 1'b0, "lb21"});
    vecs.push_back('{1'b0, 2'd0, 1'b1, 32'h021, 32'h0,        32'h000000AB, 1'b0, "lbu21"});
    vecs.push_back('{1'b0, 2'd1, 1'b0, 32'h022, 32'h0,        32'h00001234, 1'b0, "lh22"});
    vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h022, 32'h0,        32'h00000000, 1'b1, "lw22_misaligned"});
    vecs.push_back('{1'b1, 2'd1, 1'b0, 32'h023, 32'h00005555, 32'h00000000, 1'b1, "sh23_misaligned"});
    vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h020, 32'h0,        32'h1234AB78, 1'b0, "lw20_unchanged"});
    vecs.push_back('{1'b0, 2'd1, 1'b0, 32'h020, 32'h0,        32'hFFFFAB78, 1'b0, "lh20"});
    vecs.push_back('{1'b0, 2'd1, 1'b1, 32'h020, 32'h0,        32'h0000AB78, 1'b0, "lhu20"});
    vecs.push_back('{1'b1, 2'd1, 1'b0, 32'h022, 32'h1234BEEF, 32'h00000000, 1'b0, "sh22"});
    vecs.push_back('{1'b0, 2'd3, 1'b1, 32'h020, 32'h0,        32'hBEEFAB78, 1'b0, "size3_read"});
    vecs.push_back('{1'b0, 2'd0, 1'b0, 32'h023, 32'h0,        32'hFFFFFFBE, 1'b0, "lb23"});
    vecs.push_back('{1'b0, 2'd0, 1'b1, 32'h020, 32'h0,        32'h00000078, 1'b0, "lbu20"});
    vecs.push_back('{1'b1, 2'd2, 1'b0, 32'h400, 32'hCAFEF00D, 32'h00000000, 1'b0, "sw400"});
    vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h000, 32'h0,        32'hCAFEF00D, 1'b0, "lw000_wrap"});
    vecs.push_back('{1'b1, 2'd0, 1'b0, 32'h403, 32'h00000011, 32'h00000000, 1'b0, "sb403"});
    vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h800, 32'h0,        32'h11FEF00D, 1'b0, "lw800_wrap"});
    for (int i = 0; i < vecs.size(); i++) begin
      access(1, vecs[i].w, vecs[i].sz, vecs[i].u, vecs[i].a, vecs[i].wd, rd, e);
      chk({vecs[i].nm, "_rdata"}, rd, vecs[i].expR);
      chk({vecs[i].nm, "_err"}, 32'(e), 32'(vecs[i].expE));
    end

    // back-to-back reads with zero wait states
    access(2, 1'b1, 2'd2, 1'b0, 32'h20, 32'hA5A51111, rd, e);
    access(2, 1'b1, 2'd2, 1'b0, 32'h24, 32'h5A5A2222, rd, e);
    @(negedge clk);
    req[2] = 1; we[2] = 0; size[2] = 2'd2; uns[2] = 0; addr[2] = 32'h20;
    @(negedge clk);
    chk("b2b_ack1", 32'(ack[2]), 32'd1);
    chk("b2b_busy1", 32'(busy[2]), 32'd1);
    chk("b2b_rdata1", rdata[2], 32'hA5A51111);
    addr[2] = 32'h24;
    @(negedge clk);
    chk("b2b_idle_ack", 32'(ack[2]), 32'd0);
    chk("b2b_idle_busy", 32'(busy[2]), 32'd0);
    @(negedge clk);
    chk("b2b_ack2", 32'(ack[2]), 32'd1);
    chk("b2b_busy2", 32'(busy[2]), 32'd1);
    chk("b2b_rdata2", rdata[2], 32'h5A5A2222);
    req[2] = 0;
    @(negedge clk);
    chk("b2b_after_ack", 32'(ack[2]), 32'd0);
    chk("b2b_after_busy", 32'(busy[2]), 32'd0);
    chk("b2b_rdata_hold", rdata[2], 32'h5A5A2222);

    // randomised accesses against the byte model in window 0x100..0x13F
    for (int k = 0; k < 16; k++) begin
      logic [31:0] wv;
      wv = $urandom;
      model(1'b1, 2'd2, 1'b0, 32'h100 + 32'(4 * k), wv, mr, me);
      access(1, 1'b1, 2'd2, 1'b0, 32'h100 + 32'(4 * k), wv, rd, e);
    end
    for (int k = 0; k < 80; k++) begin
      logic        rw;
      logic [1:0]  rsz;
      logic        ru;
      logic [31:0] ra;
      logic [31:0] rwd;
      rw  = 1'($urandom_range(0, 2) == 0);
      rsz = 2'($urandom_range(0, 3));
      ru  = 1'($urandom_range(0, 1));
      ra  = 32'h100 + 32'($urandom_range(0, 63)) + (32'($urandom_range(0, 3)) << 10);
      rwd = $urandom;
      model(rw, rsz, ru, ra, rwd, mr, me);
      access(1, rw, rsz, ru, ra, rwd, rd, e);
      chk("rand_rdata", rd, mr);
      chk("rand_err", 32'(e), 32'(me));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
